// File: rtl/serial_twos_negator_pkg.sv
// rtl/serial_twos_negator_pkg.sv - shared state and mode encodings for the bit-serial negator
package serial_twos_negator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_NEG = 1'b0;
    localparam logic MODE_ABS = 1'b1;

endpackage

// File: rtl/serial_twos_negator_neg_bit_cell.sv
// rtl/serial_twos_negator_neg_bit_cell.sv - one bit of the serial two's-complement (invert, add carry)
module neg_bit_cell (
    input  logic b,
    input  logic carry_in,
    input  logic invert,
    output logic r,
    output logic carry_out
);

    always_comb begin
        if (invert) begin
            r         = ~b ^ carry_in;
            carry_out = ~b & carry_in;
        end else begin
            r         = b;
            carry_out = carry_in;
        end
    end

endmodule

// File: rtl/serial_twos_negator.sv
// rtl/serial_twos_negator.sv - bit-serial negate / absolute value, LSB first, start/done handshake
module serial_twos_negator
    import serial_twos_negator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             sign_q, sign_d;
    logic             min_q, min_d;
    logic             ovf_q, ovf_d;

    logic invert;
    logic cell_r;
    logic cell_c;

    // Abs of a non-negative operand passes bits through untouched.
    assign invert = (mode_q == MODE_NEG) || sign_q;

    neg_bit_cell u_cell (
        .b         (sr_q[0]),
        .carry_in  (carry_q),
        .invert    (invert),
        .r         (cell_r),
        .carry_out (cell_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= MODE_NEG;
            sign_q  <= 1'b0;
            min_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            min_q   <= min_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        res_d   = res_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        min_d   = min_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = din;
                    res_d   = '0;
                    mode_d  = mode;
                    sign_d  = din[WIDTH-1];
                    min_d   = (din == MIN_VAL);
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sr_d    = {1'b0, sr_q[WIDTH-1:1]};
                res_d   = {cell_r, res_q[WIDTH-1:1]};
                carry_d = cell_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Final carry out is dropped; only the most-negative operand overflows.
                    dout_d  = {cell_r, res_q[WIDTH-1:1]};
                    ovf_d   = invert & min_q;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready    = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign dout     = dout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_twos_negator.sv
// tb/tb_serial_twos_negator.sv - directed self-checking bench for serial_twos_negator (WIDTH 8 and 16)
module tb_serial_twos_negator;

    logic        clk;
    logic        reset;

    logic        start8, mode8;
    logic [7:0]  din8;
    logic        ready8, busy8, done8, ovf8;
    logic [7:0]  dout8;

    logic        start16, mode16;
    logic [15:0] din16;
    logic        ready16, busy16, done16, ovf16;
    logic [15:0] dout16;

    int checks;
    int errors;

    serial_twos_negator #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .mode     (mode8),
        .din      (din8),
        .ready    (ready8),
        .busy     (busy8),
        .done     (done8),
        .dout     (dout8),
        .overflow (ovf8)
    );

    serial_twos_negator #(.WIDTH(16)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .start    (start16),
        .mode     (mode16),
        .din      (din16),
        .ready    (ready16),
        .busy     (busy16),
        .done     (done16),
        .dout     (dout16),
        .overflow (ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns the cycle (counted from the accepting edge) in which done is seen, 0 on timeout.
    task automatic run8(input logic [7:0] d, input logic m, output int lat);
        @(negedge clk);
        start8 = 1'b1;
        din8   = d;
        mode8  = m;
        @(negedge clk);
        start8 = 1'b0;
        din8   = ~d;
        mode8  = ~m;
        lat    = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done8) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run16(input logic [15:0] d, input logic m, output int lat);
        @(negedge clk);
        start16 = 1'b1;
        din16   = d;
        mode16  = m;
        @(negedge clk);
        start16 = 1'b0;
        din16   = ~d;
        lat     = 0;
        for (int n = 1; n <= 60; n++) begin
            if (done16) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int last_done;
        logic [7:0] seen_dout;

        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        start8  = 1'b0; mode8  = 1'b0; din8  = '0;
        start16 = 1'b0; mode16 = 1'b0; din16 = '0;

        #1;
        check("rst_ready", ready8, 1'b1);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_dout", dout8, 8'h00);
        check("rst_ovf", ovf8, 1'b0);
        check("rst_dout16", dout16, 16'h0000);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First operation: handshake timing in detail
        @(negedge clk);
        start8 = 1'b1; din8 = 8'h01; mode8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; din8 = 8'h55;
        check("hs_ready_low", ready8, 1'b0);
        check("hs_busy_high", busy8, 1'b1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done8) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        check("hs_latency", lat, 9);
        check("hs_dout", dout8, 8'hFF);
        check("hs_ovf", ovf8, 1'b0);
        check("hs_ready_in_done", ready8, 1'b0);
        check("hs_busy_in_done", busy8, 1'b0);
        @(negedge clk);
        check("hs_ready_back", ready8, 1'b1);
        check("hs_done_one_cycle", done8, 1'b0);
        check("hs_dout_held", dout8, 8'hFF);

        run8(8'h00, 1'b0, lat);
        check("neg00_lat", lat, 9);
        check("neg00_dout", dout8, 8'h00);
        check("neg00_ovf", ovf8, 1'b0);

        run8(8'hF6, 1'b1, lat);
        check("absF6_dout", dout8, 8'h0A);
        check("absF6_ovf", ovf8, 1'b0);

        run8(8'h05, 1'b1, lat);
        check("abs05_dout", dout8, 8'h05);
        check("abs05_ovf", ovf8, 1'b0);

        run8(8'h05, 1'b0, lat);
        check("neg05_dout", dout8, 8'hFB);
        check("neg05_ovf", ovf8, 1'b0);

        run8(8'h80, 1'b0, lat);
        check("neg80_dout", dout8, 8'h80);
        check("neg80_ovf", ovf8, 1'b1);

        run8(8'h80, 1'b1, lat);
        check("abs80_dout", dout8, 8'h80);
        check("abs80_ovf", ovf8, 1'b1);

        // start while busy must be ignored
        @(negedge clk);
        start8 = 1'b1; din8 = 8'h01; mode8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; din8 = 8'h7F; mode8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses    = 0;
        seen_dout = 8'h00;
        for (int n = 0; n < 16; n++) begin
            if (done8) begin
                pulses++;
                seen_dout = dout8;
            end
            @(negedge clk);
        end
        check("busy_start_pulses", pulses, 1);
        check("busy_start_dout", seen_dout, 8'hFF);

        // Asynchronous reset during RUN after a result with overflow is held
        run8(8'h80, 1'b0, lat);
        check("pre_rst_ovf", ovf8, 1'b1);
        @(negedge clk);
        start8 = 1'b1; din8 = 8'h05; mode8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", ready8, 1'b1);
        check("mid_rst_busy", busy8, 1'b0);
        check("mid_rst_dout", dout8, 8'h00);
        check("mid_rst_ovf", ovf8, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("mid_rst_no_done", pulses, 0);

        run8(8'h05, 1'b0, lat);
        check("post_rst_lat", lat, 9);
        check("post_rst_dout", dout8, 8'hFB);

        // WIDTH=16 instance
        run16(16'h1234, 1'b0, lat);
        check("w16_lat", lat, 17);
        check("w16_neg_dout", dout16, 16'hEDCC);
        check("w16_neg_ovf", ovf16, 1'b0);

        run16(16'h8000, 1'b1, lat);
        check("w16_abs_min_dout", dout16, 16'h8000);
        check("w16_abs_min_ovf", ovf16, 1'b1);

        // Back-to-back: start held high, accepted on every ready cycle
        @(negedge clk);
        start16 = 1'b1; din16 = 16'h0003; mode16 = 1'b0;
        pulses    = 0;
        last_done = -1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done16) begin
                check("b2b_dout", dout16, 16'hFFFD);
                if (last_done >= 0) check("b2b_gap", n - last_done, 18);
                last_done = n;
                pulses++;
            end
        end
        start16 = 1'b0;
        check("b2b_pulses", pulses, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
